// File: rtl/fir_dec_out.sv
// fir_dec_out: rounds/saturates the 23-bit FIR stream back to Q2.8, decimates by M
// and buffers the result in a small FIFO read through a valid/ready handshake.
module fir_dec_out #(
   parameter int INBIT  = 23,
   parameter int OUTBIT = 11,
   parameter int FRAC   = 8,
   parameter int M      = 4,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [INBIT-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUTBIT-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     sat,
   output logic                     overflow
);
   localparam int PW = M > 1 ? $clog2(M) : 1;
   localparam int LW = $clog2(DEPTH);
   localparam int RW = INBIT - FRAC + 1;
   localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUTBIT - 1) - 1);
   localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OUTBIT - 1)));
   logic [PW-1:0] ph;
   logic signed [INBIT:0] sum;
   logic signed [RW-1:0] r;
   logic hi, lo, take, rd, wr, full;
   logic [OUTBIT-1:0] sv, s_data;
   logic s_valid;
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic [OUTBIT-1:0] mem [DEPTH];
   // one extra bit keeps the rounding offset from wrapping at the positive limit
   always_comb begin
      take = in_valid && ph == '0;
      sum  = $signed({in_data[INBIT-1], in_data}) + $signed((INBIT+1)'(1) << (FRAC - 1));
      r    = sum[INBIT:FRAC];
      hi   = r > MAXV;
      lo   = r < MINV;
      sv   = hi ? {1'b0, {(OUTBIT-1){1'b1}}} : lo ? {1'b1, {(OUTBIT-1){1'b0}}} : r[OUTBIT-1:0];
      full = fifo_level == (LW+1)'(DEPTH);
      rd   = out_valid && out_ready;
      wr   = s_valid && (!full || rd);
   end
   assign out_valid = fifo_level != '0;
   assign out_data  = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph      <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         sat     <= 1'b0;
      end else begin
         ph      <= in_valid ? (ph == PW'(M - 1) ? '0 : ph + 1'b1) : ph;
         s_valid <= take;
         s_data  <= take ? sv : s_data;
         sat     <= take && (hi || lo);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr) mem[wr_ptr] <= s_data;
         wr_ptr     <= wr ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr     <= rd ? rd_ptr + 1'b1 : rd_ptr;
         fifo_level <= fifo_level + (LW+1)'(wr) - (LW+1)'(rd);
         overflow   <= overflow || (s_valid && full && !rd);
      end
   end
endmodule

// File: tb/tb_fir_dec_out.sv
// tb_fir_dec_out: randomized scenario tests of fir_dec_out against an arithmetic model;
// u1 runs with M=1, u4 with the default M=4, both on shared stimulus.
module tb_fir_dec_out;
   logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
   logic [22:0] in_data = '0;
   logic v1, v4, s1, s4, o1, o4;
   logic [10:0] d1, d4;
   logic [3:0] l1, l4;
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   fir_dec_out #(.M(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(v1), .out_ready(out_ready), .out_data(d1), .fifo_level(l1), .sat(s1), .overflow(o1));
   fir_dec_out u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(v4), .out_ready(out_ready), .out_data(d4), .fifo_level(l4), .sat(s4), .overflow(o4));

   function automatic int model_round(int x);
      int t = x + 128;
      return t >= 0 ? t / 256 : -((-t + 255) / 256);
   endfunction
   function automatic int model(int x);
      int r = model_round(x);
      return r > 1023 ? 1023 : r < -1024 ? -1024 : r;
   endfunction
   function automatic logic model_sat(int x);
      int r = model_round(x);
      return r > 1023 || r < -1024;
   endfunction

   task automatic do_reset;
      rst = 0; in_valid = 0; out_ready = 0; in_data = '0;
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic send1(input int x, output logic va0, output logic sa, output logic va, output logic [10:0] da);
      @(negedge clk); in_valid = 1; in_data = 23'(x);
      @(negedge clk); va0 = v1; sa = s1; in_valid = 0;
      @(negedge clk); va = v1; da = d1; out_ready = 1;
      @(negedge clk); out_ready = 0;
   endtask

   task automatic test_reset;
      rst = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      nvec++;
      if ({v1, d1, l1, s1, o1} !== '0) begin
         nerr++; $display("FAIL reset_hold: got v=%b d=%0d l=%0d s=%b o=%b want all 0", v1, d1, l1, s1, o1);
      end
      rst = 1;
      @(negedge clk);
      nvec++;
      if ({v1, d1, l1, s1, o1, v4, l4} !== '0) begin
         nerr++; $display("FAIL reset_release: got v=%b d=%0d l=%0d s=%b o=%b want all 0", v1, d1, l1, s1, o1);
      end
   endtask

   task automatic test_rounding;
      int vals[5] = '{256, 383, 384, -384, -385};
      logic va0, sa, va;
      logic [10:0] da;
      do_reset;
      foreach (vals[i]) begin
         send1(vals[i], va0, sa, va, da);
         nvec++;
         if (va0 !== 1'b0 || va !== 1'b1 || da !== 11'(model(vals[i])) || sa !== 1'b0) begin
            nerr++;
            $display("FAIL round[%0d]: in=%0d got v1cyc=%b v2cyc=%b d=%0d sat=%b want 0 1 %0d 0",
               i, vals[i], va0, va, $signed(da), sa, model(vals[i]));
         end
      end
   endtask

   task automatic test_saturation;
      int vals[3] = '{300000, -300000, 261887};
      int x;
      logic va0, sa, va;
      logic [10:0] da;
      do_reset;
      for (int i = 0; i < 15; i++) begin
         x = i < 3 ? vals[i] : int'($urandom_range(0, 800000)) - 400000;
         send1(x, va0, sa, va, da);
         nvec++;
         if (va !== 1'b1 || da !== 11'(model(x)) || sa !== model_sat(x)) begin
            nerr++;
            $display("FAIL sat[%0d]: in=%0d got v=%b d=%0d sat=%b want 1 %0d %b",
               i, x, va, $signed(da), sa, model(x), model_sat(x));
         end
      end
   endtask

   task automatic test_decimation;
      int exp[$], got[$];
      int n = 0, acc = 0;
      do_reset;
      out_ready = 1;
      for (int c = 0; c < 80 && (n < 12 || c < 60); c++) begin
         @(negedge clk);
         if (v4) got.push_back(int'($signed(d4)));
         in_valid = 0;
         if (n < 12 && $urandom_range(0, 2) != 0) begin
            in_valid = 1; in_data = 23'(n * 256);
            if (acc % 4 == 0) exp.push_back(model(n * 256));
            acc++; n++;
         end
      end
      in_valid = 0; out_ready = 0;
      nvec++;
      if (got.size() != 3 || exp.size() != 3) begin
         nerr++; $display("FAIL dec_count: got %0d outputs want 3 (model %0d)", got.size(), exp.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         nvec++;
         if (got[i] != exp[i]) begin
            nerr++; $display("FAIL dec[%0d]: got %0d want %0d", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_overflow;
      int exp[$];
      int x;
      do_reset;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         x = int'($urandom_range(0, 400000)) - 200000;
         in_valid = 1; in_data = 23'(x);
         if (i < 8) exp.push_back(model(x));
      end
      @(negedge clk); in_valid = 0;
      repeat (2) @(negedge clk);
      nvec++;
      if (l1 !== 4'd8 || o1 !== 1'b1 || v1 !== 1'b1 || d1 !== 11'(exp[0])) begin
         nerr++; $display("FAIL ovf_full: got l=%0d o=%b v=%b d=%0d want 8 1 1 %0d", l1, o1, v1, $signed(d1), exp[0]);
      end
      @(negedge clk);
      nvec++;
      if (d1 !== 11'(exp[0]) || l1 !== 4'd8) begin
         nerr++; $display("FAIL ovf_stable: got d=%0d l=%0d want %0d 8", $signed(d1), l1, exp[0]);
      end
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (v1 !== 1'b1 || d1 !== 11'(exp[i])) begin
            nerr++; $display("FAIL ovf_drain[%0d]: got v=%b d=%0d want 1 %0d", i, v1, $signed(d1), exp[i]);
         end
         @(negedge clk);
      end
      out_ready = 0;
      nvec++;
      if (v1 !== 1'b0 || l1 !== 4'd0 || o1 !== 1'b1) begin
         nerr++; $display("FAIL ovf_empty: got v=%b l=%0d o=%b want 0 0 1", v1, l1, o1);
      end
   endtask

   task automatic test_full_rw;
      int exp[$];
      int x;
      do_reset;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         x = int'($urandom_range(0, 200000)) - 100000;
         in_valid = (i < 8); in_data = 23'(x);
         if (i < 8) exp.push_back(model(x));
      end
      @(negedge clk);
      nvec++;
      if (l1 !== 4'd8) begin
         nerr++; $display("FAIL frw_fill: got l=%0d want 8", l1);
      end
      x = int'($urandom_range(0, 200000)) - 100000;
      in_valid = 1; in_data = 23'(x);
      @(negedge clk); in_valid = 0; out_ready = 1;
      nvec++;
      if (d1 !== 11'(exp[0])) begin
         nerr++; $display("FAIL frw_head: got %0d want %0d", $signed(d1), exp[0]);
      end
      void'(exp.pop_front());
      exp.push_back(model(x));
      @(negedge clk); out_ready = 0;
      nvec++;
      if (l1 !== 4'd8 || o1 !== 1'b0) begin
         nerr++; $display("FAIL frw_level: got l=%0d o=%b want 8 0", l1, o1);
      end
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (v1 !== 1'b1 || d1 !== 11'(exp[i])) begin
            nerr++; $display("FAIL frw_drain[%0d]: got v=%b d=%0d want 1 %0d", i, v1, $signed(d1), exp[i]);
         end
         @(negedge clk);
      end
      out_ready = 0;
      nvec++;
      if (v1 !== 1'b0 || o1 !== 1'b0) begin
         nerr++; $display("FAIL frw_empty: got v=%b o=%b want 0 0", v1, o1);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk); in_valid = 1; in_data = 23'(n * 256);
      end
      @(negedge clk); in_valid = 0;
      @(negedge clk);
      nvec++;
      if (l1 !== 4'd5 || v1 !== 1'b1) begin
         nerr++; $display("FAIL mid_pre: got l=%0d v=%b want 5 1", l1, v1);
      end
      #2 rst = 0;
      #1;
      nvec++;
      if ({v1, d1, l1, s1, o1, v4, d4, l4} !== '0) begin
         nerr++; $display("FAIL mid_async: got v=%b d=%0d l=%0d v4=%b l4=%0d want all 0", v1, $signed(d1), l1, v4, l4);
      end
      @(negedge clk); rst = 1;
      @(negedge clk); in_valid = 1; in_data = 23'(7 * 256);
      @(negedge clk); in_valid = 0;
      @(negedge clk);
      nvec++;
      if (v4 !== 1'b1 || d4 !== 11'd7 || v1 !== 1'b1 || d1 !== 11'd7 || l4 !== 4'd1) begin
         nerr++; $display("FAIL mid_first: got v4=%b d4=%0d l4=%0d v1=%b d1=%0d want 1 7 1 1 7", v4, $signed(d4), l4, v1, $signed(d1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_rounding;
      test_saturation;
      test_decimation;
      test_overflow;
      test_full_rw;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
